// File: rtl/cbrt_pkg.sv
// Shared types and helpers for the iterative cube-root block.
package cbrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_e;

  // Wide enough for the largest shift, 3*(OUT_W-1) = 30 at WIDTH=32.
  localparam int SHIFT_W = 6;

  function automatic int calcOutW(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/cbrt_term.sv
// Trial subtrahend for one root bit: (3*y*(y+1)+1) << s, evaluated without truncation.
module cbrt_term
  import cbrt_pkg::*;
#(
  parameter int OUT_W = 3
) (
  input  logic [OUT_W-1:0]   y_i,
  input  logic [SHIFT_W-1:0] s_i,
  output logic [3*OUT_W+1:0] term_o
);

  localparam int TW = 3 * OUT_W + 2;

  logic [TW-1:0] yExt;

  assign yExt   = TW'(y_i);
  assign term_o = (TW'(3) * yExt * (yExt + TW'(1)) + TW'(1)) << s_i;

endmodule

// File: rtl/cbrt_iter.sv
// Bit-serial integer cube root, one root bit per PREP/STEP pair.
// Define CBRT_REM_EN to add the rem_o port carrying a - y^3.
module cbrt_iter
  import cbrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = calcOutW(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] y_o
`ifdef CBRT_REM_EN
  ,
  output logic [WIDTH-1:0] rem_o
`endif
);

  localparam int XW = 3 * OUT_W;
  localparam int BW = XW + 2;

  state_e             state_q;
  logic [XW-1:0]      x_q, x_d;
  logic [OUT_W-1:0]   y_q, y_d, yDbl, yOut_q;
  logic [BW-1:0]      b_q, term;
  logic [SHIFT_W-1:0] s_q;
  logic               busy_q, done_q, take;

  assign yDbl   = y_q << 1;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_o    = yOut_q;

  cbrt_term #(.OUT_W(OUT_W)) uTerm (
    .y_i   (yDbl),
    .s_i   (s_q),
    .term_o(term)
  );

  // When the trial term fits, b is no wider than x, so the low slice is exact.
  always_comb begin
    take = ({2'b00, x_q} >= b_q);
    x_d  = x_q;
    y_d  = y_q;
    if (take) begin
      x_d = x_q - b_q[XW-1:0];
      y_d = y_q + OUT_W'(1);
    end
  end

`ifdef CBRT_REM_EN
  logic [WIDTH-1:0] rem_q;
  assign rem_o = rem_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      yOut_q  <= '0;
`ifdef CBRT_REM_EN
      rem_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            x_q     <= XW'(a_i);
            y_q     <= '0;
            s_q     <= SHIFT_W'(3 * (OUT_W - 1));
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          y_q     <= yDbl;
          b_q     <= term;
          state_q <= STEP;
        end
        STEP: begin
          x_q <= x_d;
          y_q <= y_d;
          if (s_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            yOut_q  <= y_d;
`ifdef CBRT_REM_EN
            rem_q   <= x_d[WIDTH-1:0];
`endif
            state_q <= DONE;
          end else begin
            s_q     <= s_q - SHIFT_W'(3);
            state_q <= PREP;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cbrt_iter.md
CBRT_ITER -- requirements
Module: cbrt_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the radicand width in bits (legal range 3..32).
REQ-002 The block SHALL have parameter OUT_W, default (WIDTH+2)/3, meaning the root width; it is derived and not overridden.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start_i, input, 1 bit: a request to begin a computation, sampled only while busy_o is low.
REQ-006 The block SHALL have port a_i, input, WIDTH bits: the unsigned radicand, captured on the edge that accepts start_i.
REQ-007 The block SHALL have port busy_o, output, 1 bit: high while a computation is in progress.
REQ-008 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse marking that y_o is valid.
REQ-009 The block SHALL have port y_o, output, OUT_W bits: floor(cbrt(a)).
REQ-010 The block SHALL have port rem_o, output, WIDTH bits: a - y^3, present only under CBRT_REM_EN.

Function
REQ-011 The block SHALL use a state machine with states IDLE, PREP, STEP and DONE.
REQ-012 IDLE SHALL move to PREP when start_i is high.
- On that transition, a_i SHALL be zero-extended to 3*OUT_W bits into x.
- y SHALL be cleared to 0.
- The shift count s SHALL be set to 3*(OUT_W-1).
REQ-013 PREP SHALL set y to 2*y and register b = (3*y'*(y'+1)+1) << s, where y' is the doubled y.
- Internal width SHALL be 3*OUT_W+2 bits, with no truncation.
REQ-014 STEP SHALL perform the compare-and-subtract:
- If x >= b, then x becomes x-b and y becomes y+1.
- If s == 0, the next state SHALL be DONE; otherwise s SHALL become s-3 and the next state PREP.
REQ-015 DONE SHALL assert done_o for exactly one cycle, load y_o from y (and rem_o from x), then return to IDLE.
REQ-016 Latency SHALL be fixed: done_o SHALL be high in cycle 2*OUT_W+1 counted from the start_i sampling edge (7 cycles for WIDTH=8), independent of the data.
REQ-017 busy_o SHALL be high in PREP and STEP, and low in IDLE and DONE.
REQ-018 start_i SHALL be ignored while busy_o is high; a start_i in the DONE cycle SHALL also be ignored.
REQ-019 y_o and rem_o SHALL hold their value from DONE until the next DONE, and SHALL be unchanged during a computation.
REQ-020 start_i held high continuously SHALL start back-to-back computations, one accepted per IDLE visit.

Reset
REQ-021 With rst high at a clock edge, the FSM SHALL go to IDLE and busy_o, done_o, y_o and rem_o SHALL all be 0.
REQ-022 Reset SHALL take priority over start_i.
REQ-023 Reset asserted mid-operation SHALL abort the computation without any done_o pulse.
REQ-024 The first start_i after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 With macro CBRT_REM_EN defined:
- rem_o SHALL exist, holding the final x, which equals a - y_o^3.
REQ-026 Without CBRT_REM_EN:
- rem_o SHALL be absent from the port list.
- No remainder output register SHALL be built.
- All other behaviour and latency SHALL be unchanged.

Structure
REQ-027 Shared package cbrt_pkg SHALL hold:
- the FSM state typedef (IDLE/PREP/STEP/DONE, 2-bit encoding);
- a function computing OUT_W from WIDTH.
REQ-028 Sub-module cbrt_term SHALL be used, a combinational unit computing (3*y*(y+1)+1) << s.
- It SHALL be parameterised by OUT_W.
- It SHALL be instantiated once, feeding the b register in PREP.

Verification
REQ-029 WIDTH=8, start with a=8 -> done_o at cycle 7, y_o=2, rem_o=0.
REQ-030 WIDTH=8, sweep a=0..255 -> y_o^3 <= a < (y_o+1)^3 for every a; a=0 -> y_o=0; a=255 -> y_o=6, rem_o=39.
REQ-031 WIDTH=16, a=65535 -> y_o=40, rem_o=1535, done_o at cycle 13.
REQ-032 WIDTH=8, start a=27, then start a=1 at cycle 3 -> second start ignored, y_o=3, one done_o pulse.
REQ-033 WIDTH=8, start a=125, rst at cycle 4 -> busy_o=0, y_o=0, no done_o; a new start with a=64 then gives y_o=4.
REQ-034 Build without CBRT_REM_EN, a=200 -> y_o=5, latency 7, rem_o absent.
